serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
- Serial-in, parallel-out receiver: collects a bit stream one bit per qualified clock and assembles it into a WIDTH-bit word.
- Receive-side counterpart of the lab's word-to-bit serializer. Feeds reassembled operands to downstream sequential logic (comparator/datapath) over a valid/ready handshake.
- Frames are delimited by a start strobe. Bits are qualified by bit_valid. An overrun flag is raised when bits arrive while a completed word is still pending.

Parameters:
- WIDTH, 32, word length in bits; legal range 2 to 64.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first received bit lands in data_out[0].

Ports:
- clk  input  1  rising-edge clock; only clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- start  input  1  frame start strobe; one-cycle pulse.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- out_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  WIDTH  last completed word.
- out_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  a frame is in progress (state SHIFT).
- overrun  output  1  one-cycle pulse: a bit was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - Takes effect immediately, no clock needed.
  - State = IDLE; shift register, bit counter and data_out = 0; out_valid, busy and overrun = 0.
  - Any partial frame is discarded.
  - Leaving reset is synchronous to clk.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - busy=0. Bits with bit_valid=1 and no start are ignored; no overrun.
  - start=1: clear shift register and counter, go to SHIFT.
  - If bit_valid=1 in the same cycle as start, that bit is captured as bit 0 of the frame.
- SHIFT:
  - busy=1. Each cycle with bit_valid=1 shifts bit_in in and increments the counter.
  - MSB_FIRST=1: shift left, new bit into bit 0. MSB_FIRST=0: shift right, new bit into bit WIDTH-1.
  - Cycles with bit_valid=0 hold the counter and shift register.
  - On the edge capturing bit WIDTH-1: data_out loads the complete word, out_valid=1, go to HOLD.
  - out_valid is visible the cycle after the last bit is presented (latency 1 clock from the last bit).
  - start=1 in SHIFT aborts the partial frame and restarts it (counter=0). A bit_valid in the same cycle becomes bit 0 of the new frame.
- HOLD:
  - busy=0, out_valid=1. data_out is stable until the handshake.
  - Handshake occurs on out_valid & out_ready. On that cycle:
    - with start=0: clear out_valid, go to IDLE;
    - with start=1: clear out_valid, go to SHIFT (start rules as in IDLE).
  - bit_valid=1 in HOLD without a completing handshake: the bit is dropped and overrun pulses high the next cycle.
  - start=1 in HOLD without a handshake is ignored, and counts as an overrun if bit_valid=1.
- data_out retains the last completed word after the handshake, until the next word completes or reset. It is never partially updated.
- Bit counter width is clog2(WIDTH)+1. The counter never wraps within a frame.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- MSB-first, back-to-back bits: WIDTH=32, MSB_FIRST=1; start with the first bit, send 0xA5A5F00F MSB-first with bit_valid=1 for 32 cycles, out_ready=1 -> out_valid high exactly 1 cycle after the 32nd bit; data_out=0xA5A5F00F; busy low from that cycle.
- Gapped bits, LSB-first: WIDTH=32, MSB_FIRST=0; send 0x00000001 LSB-first with bit_valid every other cycle -> out_valid after the 32nd valid bit, about 64 cycles after start; data_out=0x00000001; counter does not advance on idle cycles.
- Backpressure and overrun:
  - Complete 0x12345678, hold out_ready=0 for 5 cycles, drive bit_valid=1 on 3 of them -> data_out stays 0x12345678 and overrun pulses 3 times.
  - Then raise out_ready -> out_valid drops the next cycle.
- Restart mid-frame: send 10 bits of 1s, pulse start with the first bit of 0x0F0F0F0F, send 32 bits -> data_out=0x0F0F0F0F; the earlier 10 bits are discarded.
- Handshake with simultaneous start: in HOLD, assert out_ready=1, start=1 and bit_valid=1 with bit_in=1 in the same cycle -> word consumed; new frame in SHIFT with bit 0 = 1; next word completes after 31 further bits.
- Asynchronous reset mid-frame: after 20 bits, drive reset=0 between clock edges -> busy, out_valid and data_out go to 0 immediately.
  - After release, ignore bits until start.
  - A full 32-bit frame then yields the correct word.

Source files
------------

// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
//   Serial-in, parallel-out receiver. Collects one bit per cycle with
//   bit_valid=1 after a start strobe, assembles a WIDTH-bit word and offers it
//   downstream over a valid/ready handshake. Bits arriving while a completed
//   word is still pending are dropped and flagged on overrun.
//
// Parameters
//   WIDTH     : word length in bits (2..64)
//   MSB_FIRST : 1 = first received bit lands in data_out[WIDTH-1],
//               0 = first received bit lands in data_out[0]
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   frame start strobe (one-cycle pulse)
//   bit_in    in   serial data bit
//   bit_valid in   bit_in is valid this cycle
//   out_ready in   consumer accepts data_out this cycle
//   data_out  out  last completed word (registered)
//   out_valid out  data_out holds an unconsumed word (registered)
//   busy      out  a frame is in progress (registered)
//   overrun   out  one-cycle pulse: a bit was dropped (registered)
// -----------------------------------------------------------------------------
module serial_word_receiver #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  // Counter must hold WIDTH itself so it never wraps inside a frame.
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_overrun;

  logic               w_last_bit;
  logic               w_frame_start;
  logic               w_take;
  logic               w_complete;
  logic [WIDTH-1:0]   w_shift_base;
  logic [CNT_W-1:0]   w_cnt_base;
  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   w_data_nxt;
  logic               w_valid_nxt;
  logic               w_busy_nxt;
  logic               w_overrun_nxt;

  // A qualified bit this cycle is the final bit of the word.
  assign w_last_bit = bit_valid && (r_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (!start && w_last_bit) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) w_state_nxt = start ? ST_SHIFT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    // start is honoured everywhere except in HOLD without a handshake.
    w_frame_start = start && ((r_state != ST_HOLD) || out_ready);
    w_shift_base  = w_frame_start ? '0 : r_shift;
    w_cnt_base    = w_frame_start ? '0 : r_cnt;
    w_take        = bit_valid && (w_frame_start || (r_state == ST_SHIFT));

    if (MSB_FIRST) begin
      w_shifted = {w_shift_base[WIDTH-2:0], bit_in};
    end else begin
      w_shifted = {bit_in, w_shift_base[WIDTH-1:1]};
    end

    w_shift_nxt   = w_take ? w_shifted : w_shift_base;
    w_cnt_nxt     = w_cnt_base + CNT_W'(w_take);
    // A restart wins over completion of the aborted frame.
    w_complete    = (r_state == ST_SHIFT) && !start && w_last_bit;
    w_data_nxt    = w_complete ? w_shifted : r_data_out;
    w_valid_nxt   = (w_state_nxt == ST_HOLD);
    w_busy_nxt    = (w_state_nxt == ST_SHIFT);
    w_overrun_nxt = (r_state == ST_HOLD) && !out_ready && bit_valid;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_data_out  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_word_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_word_receiver
//   Two receivers (MSB-first and LSB-first) share one stimulus stream. A
//   frame-level model (bit queue + pending-word flag) predicts the outputs.
// -----------------------------------------------------------------------------
module tb_serial_word_receiver;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         out_ready;

  logic [W-1:0] msb_data_out;
  logic         msb_out_valid;
  logic         msb_busy;
  logic         msb_overrun;
  logic [W-1:0] lsb_data_out;
  logic         lsb_out_valid;
  logic         lsb_busy;
  logic         lsb_overrun;

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .out_ready(out_ready),
    .data_out(msb_data_out), .out_valid(msb_out_valid),
    .busy(msb_busy), .overrun(msb_overrun)
  );

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .out_ready(out_ready),
    .data_out(lsb_data_out), .out_valid(lsb_out_valid),
    .busy(lsb_busy), .overrun(lsb_overrun)
  );

  int checks   = 0;
  int failures = 0;
  int n_steps  = 0;

  // Frame-level reference model.
  bit           md_in_frame;
  bit           md_hold;
  bit           md_ov;
  bit           q[$];
  logic [W-1:0] md_msb;
  logic [W-1:0] md_lsb;

  function automatic logic [W-1:0] assemble(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i]) begin
        if (msb) w[W-1-i] = 1'b1;
        else     w[i]     = 1'b1;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    md_in_frame = 1'b0;
    md_hold     = 1'b0;
    md_ov       = 1'b0;
    q.delete();
    md_msb      = '0;
    md_lsb      = '0;
  endtask

  task automatic model_begin_frame();
    md_in_frame = 1'b1;
    q.delete();
    if (bit_valid) q.push_back(bit_in);
  endtask

  // Advance the model by one clock using the inputs presented right now.
  task automatic model_edge();
    md_ov = 1'b0;
    if (md_hold) begin
      if (out_ready) begin
        md_hold = 1'b0;
        if (start) model_begin_frame();
      end else if (bit_valid) begin
        md_ov = 1'b1;
      end
    end else if (start) begin
      model_begin_frame();
    end else if (md_in_frame && bit_valid) begin
      q.push_back(bit_in);
    end
    if (md_in_frame && q.size() == W) begin
      md_msb      = assemble(1'b1);
      md_lsb      = assemble(1'b0);
      md_hold     = 1'b1;
      md_in_frame = 1'b0;
      q.delete();
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    n_steps++;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input bit msb_order,
                           input int first, input int last,
                           input bit with_start, input int gap);
    int g;
    for (int i = first; i <= last; i++) begin
      start     = with_start && (i == first);
      bit_valid = 1'b1;
      bit_in    = msb_order ? w[W-1-i] : w[i];
      step();
      start     = 1'b0;
      bit_valid = 1'b0;
      if (i != last) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) begin
          bit_in = 1'($urandom);
          step();
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({msb_busy, msb_out_valid, msb_overrun, msb_data_out} !== '0) begin
      failures++;
      $display("FAIL reset_async_msb got=%b/%b/%b/%h exp=0/0/0/0",
               msb_busy, msb_out_valid, msb_overrun, msb_data_out);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({lsb_busy, lsb_out_valid, lsb_overrun, lsb_data_out} !== '0) begin
      failures++;
      $display("FAIL reset_hold_lsb got=%b/%b/%b/%h exp=0/0/0/0",
               lsb_busy, lsb_out_valid, lsb_overrun, lsb_data_out);
    end
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_msb_back_to_back();
    logic [W-1:0] w;
    w = 32'hA5A5F00F;
    out_ready = 1'b1;
    send_bits(w, 1'b1, 0, 30, 1'b1, 0);
    checks++;
    if (msb_busy !== 1'b1 || msb_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_before_last busy=%b valid=%b exp busy=1 valid=0", msb_busy, msb_out_valid);
    end
    send_bits(w, 1'b1, 31, 31, 1'b0, 0);
    checks++;
    if (msb_out_valid !== 1'b1 || msb_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_valid_latency valid=%b busy=%b exp valid=1 busy=0", msb_out_valid, msb_busy);
    end
    checks++;
    if (msb_data_out !== 32'hA5A5F00F) begin
      failures++;
      $display("FAIL b2b_data got=%h exp=%h", msb_data_out, 32'hA5A5F00F);
    end
    checks++;
    if (lsb_data_out !== md_lsb || lsb_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_lsb_data got=%h/%b exp=%h/1", lsb_data_out, lsb_out_valid, md_lsb);
    end
    step();
    checks++;
    if (msb_out_valid !== 1'b0 || msb_data_out !== 32'hA5A5F00F) begin
      failures++;
      $display("FAIL b2b_consume valid=%b data=%h exp valid=0 data=a5a5f00f", msb_out_valid, msb_data_out);
    end
  endtask

  task automatic test_lsb_gapped();
    logic [W-1:0] w;
    int n0;
    w  = 32'h00000001;
    out_ready = 1'b0;
    n0 = n_steps;
    send_bits(w, 1'b0, 0, 30, 1'b1, 1);
    bit_in = 1'b1;
    step();
    checks++;
    if (lsb_busy !== 1'b1 || lsb_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL gap_no_early_done busy=%b valid=%b exp busy=1 valid=0", lsb_busy, lsb_out_valid);
    end
    send_bits(w, 1'b0, 31, 31, 1'b0, 0);
    checks++;
    if (lsb_out_valid !== 1'b1 || lsb_data_out !== 32'h00000001) begin
      failures++;
      $display("FAIL gap_lsb_word valid=%b data=%h exp valid=1 data=00000001", lsb_out_valid, lsb_data_out);
    end
    checks++;
    if (n_steps - n0 !== 63) begin
      failures++;
      $display("FAIL gap_latency cycles=%0d exp=63", n_steps - n0);
    end
    checks++;
    if (msb_data_out !== 32'h80000000) begin
      failures++;
      $display("FAIL gap_msb_reversed got=%h exp=80000000", msb_data_out);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (lsb_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL gap_consume valid=%b exp=0", lsb_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w;
    logic [4:0]   mask;
    int           ov_cnt;
    w = 32'h12345678;
    out_ready = 1'b0;
    send_bits(w, 1'b1, 0, 31, 1'b1, 0);
    do mask = 5'($urandom); while ($countones(mask) != 3);
    ov_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      bit_valid = mask[k];
      bit_in    = 1'($urandom);
      start     = 1'($urandom);
      step();
      if (msb_overrun === 1'b1) ov_cnt++;
      checks++;
      if (msb_data_out !== 32'h12345678 || msb_out_valid !== 1'b1 || msb_overrun !== md_ov) begin
        failures++;
        $display("FAIL bp_hold_%0d data=%h valid=%b ov=%b exp data=12345678 valid=1 ov=%b",
                 k, msb_data_out, msb_out_valid, msb_overrun, md_ov);
      end
    end
    start = 1'b0; bit_valid = 1'b0; out_ready = 1'b1;
    step();
    if (msb_overrun === 1'b1) ov_cnt++;
    out_ready = 1'b0;
    checks++;
    if (ov_cnt !== 3) begin
      failures++;
      $display("FAIL bp_overrun_count got=%0d exp=3", ov_cnt);
    end
    checks++;
    if (msb_out_valid !== 1'b0 || msb_busy !== 1'b0 || msb_data_out !== 32'h12345678) begin
      failures++;
      $display("FAIL bp_release valid=%b busy=%b data=%h exp 0/0/12345678",
               msb_out_valid, msb_busy, msb_data_out);
    end
  endtask

  task automatic test_restart();
    out_ready = 1'b1;
    send_bits(32'hFFFFFFFF, 1'b1, 0, 9, 1'b1, 0);
    checks++;
    if (msb_busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_partial busy=%b exp=1", msb_busy);
    end
    send_bits(32'h0F0F0F0F, 1'b1, 0, 31, 1'b1, -1);
    checks++;
    if (msb_data_out !== 32'h0F0F0F0F || msb_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart_word data=%h valid=%b exp 0f0f0f0f/1", msb_data_out, msb_out_valid);
    end
    checks++;
    if (lsb_data_out !== md_lsb) begin
      failures++;
      $display("FAIL restart_lsb got=%h exp=%h", lsb_data_out, md_lsb);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_handshake_start();
    logic [W-1:0] w1;
    logic [W-1:0] w2;
    w1 = $urandom;
    w2 = $urandom | 32'h80000000;
    out_ready = 1'b0;
    send_bits(w1, 1'b1, 0, 31, 1'b1, -1);
    checks++;
    if (msb_out_valid !== 1'b1 || msb_data_out !== w1) begin
      failures++;
      $display("FAIL hs_first valid=%b data=%h exp 1/%h", msb_out_valid, msb_data_out, w1);
    end
    out_ready = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    out_ready = 1'b0; start = 1'b0; bit_valid = 1'b0;
    checks++;
    if (msb_out_valid !== 1'b0 || msb_busy !== 1'b1 || msb_data_out !== w1) begin
      failures++;
      $display("FAIL hs_restart valid=%b busy=%b data=%h exp 0/1/%h",
               msb_out_valid, msb_busy, msb_data_out, w1);
    end
    send_bits(w2, 1'b1, 1, 30, 1'b0, 0);
    checks++;
    if (msb_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hs_not_early valid=%b exp=0", msb_out_valid);
    end
    send_bits(w2, 1'b1, 31, 31, 1'b0, 0);
    checks++;
    if (msb_out_valid !== 1'b1 || msb_data_out !== w2) begin
      failures++;
      $display("FAIL hs_second valid=%b data=%h exp 1/%h", msb_out_valid, msb_data_out, w2);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] w;
    w = $urandom;
    out_ready = 1'b0;
    send_bits(w, 1'b1, 0, 19, 1'b1, 0);
    #3 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({msb_busy, msb_out_valid, msb_data_out} !== '0 ||
        {lsb_busy, lsb_out_valid, lsb_data_out} !== '0) begin
      failures++;
      $display("FAIL arst_immediate msb=%b/%b/%h lsb=%b/%b/%h exp all 0",
               msb_busy, msb_out_valid, msb_data_out, lsb_busy, lsb_out_valid, lsb_data_out);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      step();
    end
    bit_valid = 1'b0;
    checks++;
    if (msb_busy !== 1'b0 || msb_out_valid !== 1'b0 || msb_data_out !== '0) begin
      failures++;
      $display("FAIL arst_ignore_bits busy=%b valid=%b data=%h exp 0/0/0",
               msb_busy, msb_out_valid, msb_data_out);
    end
    w = $urandom;
    send_bits(w, 1'b1, 0, 31, 1'b1, -1);
    checks++;
    if (msb_out_valid !== 1'b1 || msb_data_out !== w) begin
      failures++;
      $display("FAIL arst_frame valid=%b data=%h exp 1/%h", msb_out_valid, msb_data_out, w);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      start     = ($urandom_range(0, 63) == 0);
      bit_valid = ($urandom_range(0, 3) != 0);
      bit_in    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if ({msb_data_out, msb_out_valid, msb_busy, msb_overrun} !==
          {md_msb, md_hold, md_in_frame, md_ov}) begin
        failures++;
        $display("FAIL rand_msb cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", c,
                 msb_data_out, msb_out_valid, msb_busy, msb_overrun,
                 md_msb, md_hold, md_in_frame, md_ov);
      end
      checks++;
      if ({lsb_data_out, lsb_out_valid, lsb_busy, lsb_overrun} !==
          {md_lsb, md_hold, md_in_frame, md_ov}) begin
        failures++;
        $display("FAIL rand_lsb cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", c,
                 lsb_data_out, lsb_out_valid, lsb_busy, lsb_overrun,
                 md_lsb, md_hold, md_in_frame, md_ov);
      end
    end
    start = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_msb_back_to_back();
    test_lsb_gapped();
    test_backpressure();
    test_restart();
    test_handshake_start();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
